store_narrow_rmw: RTL and testbench

- Store-side counterpart of the load/immediate extension path: narrows a 32-bit store operand to byte/halfword width and merges it into a word-wide data RAM.
- Sub-word stores (sb/sh) use a read-modify-write sequence; aligned word stores (sw) write directly.
- Sits between the MEM stage and a synchronous single-port 32-bit data RAM. It stalls the pipeline via req_ready while busy.

---
 rtl/store_narrow_rmw.sv | 144 ++++++++++++++
 tb/tb_store_narrow_rmw.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/store_narrow_rmw.sv
// Store-side narrowing unit: merges byte/halfword stores into a word-wide RAM
// via read-modify-write, while aligned word stores are written directly.
module store_narrow_rmw #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] data_r;
  logic [31:0] old_r;
  logic [1:0]  size_r;
  logic [1:0]  lane_r;
  logic        bad_req;
  logic        unused_addr_bits;

  // Bits above the RAM word address only make addresses wrap.
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic result;
    case (size)
      2'b00:   result = 1'b0;
      2'b01:   result = lo[0];
      2'b10:   result = (lo != 2'b00);
      default: result = 1'b1;
    endcase
    return result;
  endfunction

  // Little-endian lane merge of the store operand into the old RAM word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] w;
    w = old;
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   w[7:0]   = data[7:0];
          2'b01:   w[15:8]  = data[7:0];
          2'b10:   w[23:16] = data[7:0];
          2'b11:   w[31:24] = data[7:0];
          default: w = old;
        endcase
      end
      2'b01: begin
        if (lane[1]) w[31:16] = data[15:0];
        else         w[15:0]  = data[15:0];
      end
      default: w = data;
    endcase
    return w;
  endfunction

  assign bad_req   = misaligned(req_size, req_addr[1:0]);
  assign mem_wdata = merge(old_r, data_r, size_r, lane_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      data_r    <= 32'd0;
      old_r     <= 32'd0;
      size_r    <= 2'b00;
      lane_r    <= 2'b00;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            data_r    <= req_data;
            size_r    <= req_size;
            lane_r    <= req_addr[1:0];
            mem_addr  <= req_addr[ADDR_W+1:2];
            req_ready <= 1'b0;
            if (bad_req) begin
              state <= ERR;
              err   <= 1'b1;
            end else if (req_size == 2'b10) begin
              state  <= WRITE;
              mem_we <= 1'b1;
              done   <= 1'b1;
            end else begin
              state  <= READ;
              mem_rd <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          // RAM data returned for the READ cycle is valid only now.
          old_r  <= mem_rdata;
          state  <= WRITE;
          mem_we <= 1'b1;
          done   <= 1'b1;
        end
        WRITE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        ERR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw with a behavioural synchronous RAM and
// hand-computed expected words.
module tb_store_narrow_rmw;

  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_data = 32'd0;
  logic [1:0]        req_size = 2'b00;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = 32'd0;
  int                we_cnt = 0;
  int                both_cnt = 0;
  int                n_assert = 0;
  int                n_fail = 0;

  store_narrow_rmw #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .done(done), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM plus a bench-side preload port.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= ram[mem_addr];
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_we && mem_rd) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Presents a request for one edge; returns at the negedge of cycle T+1.
  task automatic start(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int acc[$];
    int low;
    int we_base;

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_strobes", {28'd0, done, err, mem_rd, mem_we}, 32'd0);
    chk("rst_addr", {21'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    preload(11'd1, 32'h11223344);
    preload(11'd2, 32'h11223344);

    // Byte store, lane 1
    start(32'h005, 32'hAABBCCDD, 2'b00);
    chk("byte_t1_rd", {30'd0, mem_rd, mem_we}, 32'd2);
    chk("byte_t1_addr", {21'd0, mem_addr}, 32'd1);
    chk("byte_t1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("byte_t2_strobes", {29'd0, mem_rd, mem_we, done}, 32'd0);
    @(negedge clk);
    chk("byte_t3_we", {29'd0, mem_rd, mem_we, done}, 32'd3);
    chk("byte_t3_wdata", mem_wdata, 32'h1122DD44);
    chk("byte_t3_addr", {21'd0, mem_addr}, 32'd1);
    chk("byte_t3_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("byte_t4_ready", {30'd0, req_ready, mem_we}, 32'd2);
    chk("byte_ram", ram[1], 32'h1122DD44);

    // Half stores, upper then lower
    start(32'h00A, 32'h0000BEEF, 2'b01);
    chk("half_hi_t1_rd", {30'd0, mem_rd, mem_we}, 32'd2);
    @(negedge clk);
    @(negedge clk);
    chk("half_hi_t3_we", {30'd0, mem_rd, mem_we}, 32'd1);
    chk("half_hi_wdata", mem_wdata, 32'hBEEF3344);
    @(negedge clk);
    preload(11'd2, 32'h11223344);
    start(32'h008, 32'h0000BEEF, 2'b01);
    @(negedge clk);
    @(negedge clk);
    chk("half_lo_t3_we", {30'd0, mem_rd, mem_we}, 32'd1);
    chk("half_lo_wdata", mem_wdata, 32'h1122BEEF);
    @(negedge clk);

    // Aligned word store, with upper address bits that must wrap
    start(32'h0000200C, 32'hDEADBEEF, 2'b10);
    chk("word_t1_strobes", {29'd0, mem_rd, mem_we, done}, 32'd3);
    chk("word_t1_addr", {21'd0, mem_addr}, 32'd3);
    chk("word_t1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("word_t1_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("word_t2_ready", {30'd0, req_ready, mem_we}, 32'd2);
    chk("word_ram", ram[3], 32'hDEADBEEF);

    // Error requests: misaligned half, misaligned word, reserved size
    start(32'h003, 32'h12345678, 2'b01);
    chk("err_half_t1", {28'd0, err, mem_rd, mem_we, req_ready}, 32'd8);
    @(negedge clk);
    chk("err_half_t2", {28'd0, err, mem_rd, mem_we, req_ready}, 32'd1);
    start(32'h006, 32'h12345678, 2'b10);
    chk("err_word_t1", {28'd0, err, mem_rd, mem_we, req_ready}, 32'd8);
    @(negedge clk);
    chk("err_word_t2", {28'd0, err, mem_rd, mem_we, req_ready}, 32'd1);
    start(32'h004, 32'h12345678, 2'b11);
    chk("err_rsv_t1", {28'd0, err, mem_rd, mem_we, req_ready}, 32'd8);
    @(negedge clk);
    chk("err_rsv_t2", {28'd0, err, mem_rd, mem_we, req_ready}, 32'd1);

    // Back-to-back byte stores with req_valid held high
    preload(11'd4, 32'h00000000);
    low = 0;
    req_valid = 1'b1; req_addr = 32'h010; req_data = 32'h000000A5; req_size = 2'b00;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) acc.push_back(c);
      else low++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_count", acc.size(), 32'd3);
    if (acc.size() == 3) begin
      chk("b2b_gap1", acc[1] - acc[0], 32'd4);
      chk("b2b_gap2", acc[2] - acc[1], 32'd4);
    end
    chk("b2b_low", low, 32'd9);
    chk("b2b_ram", ram[4], 32'h000000A5);

    // Reset asserted while in WAIT
    preload(11'd5, 32'hCAFEF00D);
    start(32'h015, 32'h00000077, 2'b00);
    @(negedge clk);
    we_base = we_cnt;
    rst = 1'b1;
    #1;
    chk("rstw_strobes", {27'd0, done, err, mem_rd, mem_we, req_ready}, 32'd1);
    chk("rstw_addr", {21'd0, mem_addr}, 32'd0);
    chk("rstw_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_no_we", we_cnt, we_base);
    chk("rstw_ram", ram[5], 32'hCAFEF00D);
    start(32'h015, 32'h00000077, 2'b00);
    @(negedge clk);
    @(negedge clk);
    chk("rstw_next_we", {30'd0, mem_we, done}, 32'd3);
    chk("rstw_next_wdata", mem_wdata, 32'hCAFE770D);
    @(negedge clk);
    chk("rstw_next_ram", ram[5], 32'hCAFE770D);
    chk("strobe_excl", both_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
